// File: rtl/player_input_frontend.sv
// player_input_frontend
//   Conditions NUM_PLAYERS raw button buses (2-flop sync, optional inversion,
//   per-bit debounce), latches them once per video frame on the falling edge of
//   vsync, and reports frame-stable levels plus pressed/released edges.
//   Optional per-player run-length input history, built only when the
//   INPUT_HISTORY_EN macro is defined; otherwise the hist_* outputs are 0.
module player_input_frontend #(
  parameter int NUM_PLAYERS       = 2,
  parameter int INPUT_WIDTH       = 5,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int ACTIVE_LOW_INPUTS = 1,
  parameter int HISTORY_DEPTH     = 8,
  localparam int PSEL_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int IDX_W  = $clog2(HISTORY_DEPTH),
  localparam int CNT_W  = $clog2(HISTORY_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PLAYERS*INPUT_WIDTH-1:0] raw_inputs,
  input  logic                               vsync,
  output logic                               frame_tick,
  output logic                               frame_valid,
  output logic [NUM_PLAYERS*INPUT_WIDTH-1:0] inputs_frame,
  output logic [NUM_PLAYERS*INPUT_WIDTH-1:0] pressed_edge,
  output logic [NUM_PLAYERS*INPUT_WIDTH-1:0] released_edge,
  input  logic [PSEL_W-1:0]                  hist_rd_player,
  input  logic [IDX_W-1:0]                   hist_rd_index,
  output logic [INPUT_WIDTH+7:0]             hist_rd_data,
  output logic                               hist_rd_hit,
  output logic [NUM_PLAYERS*CNT_W-1:0]       hist_count
);

  localparam int NB    = NUM_PLAYERS * INPUT_WIDTH;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  // Raw value that reads as "released" once the optional inversion is applied.
  localparam logic [NB-1:0] SYNC_IDLE = (ACTIVE_LOW_INPUTS != 0) ? '1 : '0;

  logic [NB-1:0]    sync_q1;
  logic [NB-1:0]    sync_q2;
  logic [NB-1:0]    sync_lvl;
  logic [NB-1:0]    stable;
  logic [DEB_W-1:0] deb_cnt [NB];
  logic             vsync_d;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= SYNC_IDLE;
      sync_q2 <= SYNC_IDLE;
    end else begin
      sync_q1 <= raw_inputs;
      sync_q2 <= sync_q1;
    end
  end

  assign sync_lvl = (ACTIVE_LOW_INPUTS != 0) ? ~sync_q2 : sync_q2;

  // Per-bit debounce: a new level must persist DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync_lvl[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= sync_lvl[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed vsync for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= vsync;
    end
  end

  assign frame_tick = vsync_d & ~vsync;

  // Frame latch: levels and edges update together, one cycle after frame_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_valid   <= 1'b0;
      inputs_frame  <= '0;
      pressed_edge  <= '0;
      released_edge <= '0;
    end else begin
      frame_valid <= frame_tick;
      if (frame_tick) begin
        inputs_frame  <= stable;
        pressed_edge  <= stable & ~inputs_frame;
        released_edge <= ~stable & inputs_frame;
      end
    end
  end

`ifdef INPUT_HISTORY_EN
  localparam logic [CNT_W-1:0] HD_CNT = CNT_W'(HISTORY_DEPTH);

  logic [INPUT_WIDTH+7:0] hist_mem [NUM_PLAYERS][HISTORY_DEPTH];
  logic [IDX_W-1:0]       wr_ptr   [NUM_PLAYERS];
  logic [CNT_W-1:0]       count    [NUM_PLAYERS];
  logic [INPUT_WIDTH+7:0] newest   [NUM_PLAYERS];
  logic [INPUT_WIDTH-1:0] new_word [NUM_PLAYERS];
  logic                   push     [NUM_PLAYERS];
  logic                   rd_player_ok;
  logic [PSEL_W-1:0]      rd_sel;
  logic [IDX_W-1:0]       rd_addr;
  logic                   rd_hit_c;

  // Newest entry and push decision per player.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      new_word[p] = stable[p*INPUT_WIDTH +: INPUT_WIDTH];
      newest[p]   = hist_mem[p][wr_ptr[p] - 1'b1];
      push[p]     = (count[p] == '0) || (new_word[p] != newest[p][INPUT_WIDTH-1:0]);
    end
  end

  // Run-length history: push on change, otherwise extend the newest duration.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        wr_ptr[p] <= '0;
        count[p]  <= '0;
      end
    end else if (frame_tick) begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        if (push[p]) begin
          hist_mem[p][wr_ptr[p]] <= {8'd1, new_word[p]};
          wr_ptr[p]              <= wr_ptr[p] + 1'b1;
          if (count[p] != HD_CNT) begin
            count[p] <= count[p] + 1'b1;
          end
        end else if (newest[p][INPUT_WIDTH+7:INPUT_WIDTH] != 8'hFF) begin
          hist_mem[p][wr_ptr[p] - 1'b1] <=
            {newest[p][INPUT_WIDTH+7:INPUT_WIDTH] + 8'd1, newest[p][INPUT_WIDTH-1:0]};
        end
      end
    end
  end

  // Read address decode; out-of-range players are folded to 0 and forced to miss.
  always_comb begin
    rd_player_ok = 32'(hist_rd_player) < NUM_PLAYERS;
    rd_sel       = rd_player_ok ? hist_rd_player : '0;
    rd_addr      = wr_ptr[rd_sel] - 1'b1 - hist_rd_index;
    rd_hit_c     = rd_player_ok && (CNT_W'(hist_rd_index) < count[rd_sel]);
  end

  // Registered read port; returns contents as of before this cycle's update.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_rd_data <= '0;
      hist_rd_hit  <= 1'b0;
    end else begin
      hist_rd_hit  <= rd_hit_c;
      hist_rd_data <= rd_hit_c ? hist_mem[rd_sel][rd_addr] : '0;
    end
  end

  // Pack per-player entry counts.
  always_comb begin
    hist_count = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      hist_count[p*CNT_W +: CNT_W] = count[p];
    end
  end
`else
  logic unused_hist_rd;

  assign unused_hist_rd = ^{hist_rd_player, hist_rd_index};
  assign hist_rd_data   = '0;
  assign hist_rd_hit    = 1'b0;
  assign hist_count     = '0;
`endif

endmodule

// File: tb/tb_player_input_frontend.sv
// Directed self-checking bench for player_input_frontend (DEB=4, NP=2, IW=5, HD=8).
module tb_player_input_frontend;

`ifdef INPUT_HISTORY_EN
  localparam bit HEN = 1'b1;
`else
  localparam bit HEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  raw_inputs;
  logic        vsync;
  logic        frame_tick;
  logic        frame_valid;
  logic [9:0]  inputs_frame;
  logic [9:0]  pressed_edge;
  logic [9:0]  released_edge;
  logic [0:0]  hist_rd_player;
  logic [2:0]  hist_rd_index;
  logic [12:0] hist_rd_data;
  logic        hist_rd_hit;
  logic [7:0]  hist_count;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  player_input_frontend #(
    .NUM_PLAYERS      (2),
    .INPUT_WIDTH      (5),
    .DEBOUNCE_CYCLES  (4),
    .ACTIVE_LOW_INPUTS(1),
    .HISTORY_DEPTH    (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .raw_inputs    (raw_inputs),
    .vsync         (vsync),
    .frame_tick    (frame_tick),
    .frame_valid   (frame_valid),
    .inputs_frame  (inputs_frame),
    .pressed_edge  (pressed_edge),
    .released_edge (released_edge),
    .hist_rd_player(hist_rd_player),
    .hist_rd_index (hist_rd_index),
    .hist_rd_data  (hist_rd_data),
    .hist_rd_hit   (hist_rd_hit),
    .hist_count    (hist_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One vsync low pulse with frame_tick / frame_valid timing checks.
  task automatic frame();
    vsync = 1'b0;
    #1;
    chk("frame_tick_hi", frame_tick, 1);
    chk("frame_valid_pre", frame_valid, 0);
    cyc();
    chk("frame_valid_hi", frame_valid, 1);
    chk("frame_tick_lo", frame_tick, 0);
    vsync = 1'b1;
    cyc();
    chk("frame_valid_lo", frame_valid, 0);
  endtask

  task automatic chk_frame(input string tag, input logic [9:0] f, input logic [9:0] p,
                           input logic [9:0] r);
    chk({tag, "_frame"}, inputs_frame, f);
    chk({tag, "_pressed"}, pressed_edge, p);
    chk({tag, "_released"}, released_edge, r);
  endtask

  task automatic hist_read(input string tag, input logic pl, input logic [2:0] idx,
                           input logic [12:0] exp_data, input logic exp_hit);
    hist_rd_player = pl;
    hist_rd_index  = idx;
    cyc();
    chk({tag, "_data"}, hist_rd_data, HEN ? exp_data : 13'd0);
    chk({tag, "_hit"}, hist_rd_hit, HEN ? exp_hit : 1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    raw_inputs     = '1;
    vsync          = 1'b1;
    hist_rd_player = '0;
    hist_rd_index  = '0;
    cyc(3);
    chk_frame("reset", 10'h000, 10'h000, 10'h000);
    chk("reset_valid", frame_valid, 0);
    chk("reset_tick", frame_tick, 0);
    chk("reset_count", hist_count, 0);
    chk("reset_rd_data", hist_rd_data, 0);
    chk("reset_rd_hit", hist_rd_hit, 0);
    reset = 1'b0;
    cyc(3);

    // T1: all released, frames leave outputs at 0
    frame();
    chk_frame("t1a", 10'h000, 10'h000, 10'h000);
    frame();
    chk_frame("t1b", 10'h000, 10'h000, 10'h000);

    // T2: 3-cycle glitch is rejected, 4+ cycle hold is accepted
    raw_inputs[0] = 1'b0;
    cyc(3);
    raw_inputs[0] = 1'b1;
    cyc(10);
    frame();
    chk_frame("t2_glitch", 10'h000, 10'h000, 10'h000);
    raw_inputs[0] = 1'b0;
    cyc(10);
    chk_frame("t2_hold_between", 10'h000, 10'h000, 10'h000);
    frame();
    chk_frame("t2_press", 10'h001, 10'h001, 10'h000);
    frame();
    chk_frame("t2_next", 10'h001, 10'h000, 10'h000);

    // T3: press P2 bit4, then release so stable falls on the frame_tick cycle
    raw_inputs[9] = 1'b0;
    cyc(10);
    frame();
    chk_frame("t3_press", 10'h201, 10'h200, 10'h000);
    raw_inputs[9] = 1'b1;
    cyc(5);
    frame();
    chk_frame("t3_race_old", 10'h201, 10'h000, 10'h000);
    frame();
    chk_frame("t3_release", 10'h001, 10'h000, 10'h200);
    frame();
    chk_frame("t3_release_once", 10'h001, 10'h000, 10'h000);

    // T4: reset with bit0 held, then 300 frames of the same word
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(10);
    frame();
    chk_frame("t4_held_reset", 10'h001, 10'h001, 10'h000);
    for (int i = 0; i < 299; i++) begin
      frame();
    end
    chk_frame("t4_steady", 10'h001, 10'h000, 10'h000);
    chk("t4_count_a", hist_count, HEN ? 8'h11 : 8'h00);
    hist_read("t4_p1_i0", 1'b0, 3'd0, 13'h1FE1, 1'b1);
    hist_read("t4_p1_i1", 1'b0, 3'd1, 13'h0000, 1'b0);
    raw_inputs[4:0] = 5'b11101;
    cyc(10);
    frame();
    chk_frame("t4_change", 10'h002, 10'h002, 10'h001);
    chk("t4_count_b", hist_count, HEN ? 8'h12 : 8'h00);
    hist_read("t4b_p1_i0", 1'b0, 3'd0, 13'h0022, 1'b1);
    hist_read("t4b_p1_i1", 1'b0, 3'd1, 13'h1FE1, 1'b1);
    hist_read("t4b_p2_i0", 1'b1, 3'd0, 13'h1FE0, 1'b1);

    // T5: 10 distinct words (3..12) overflow the 8-deep history
    for (int k = 0; k < 10; k++) begin
      raw_inputs[4:0] = ~5'(k + 3);
      cyc(10);
      frame();
    end
    chk_frame("t5_last", 10'h00C, 10'h004, 10'h003);
    chk("t5_count", hist_count, HEN ? 8'h18 : 8'h00);
    hist_read("t5_p1_i0", 1'b0, 3'd0, 13'h002C, 1'b1);
    hist_read("t5_p1_i7", 1'b0, 3'd7, 13'h0025, 1'b1);
    hist_read("t5_p2_i1_miss", 1'b1, 3'd1, 13'h0000, 1'b0);

    // Reset asserted on a frame_tick cycle discards everything
    hist_rd_player = 1'b0;
    hist_rd_index  = 3'd0;
    vsync = 1'b0;
    reset = 1'b1;
    #1;
    cyc();
    chk_frame("t5_rst", 10'h000, 10'h000, 10'h000);
    chk("t5_rst_valid", frame_valid, 0);
    chk("t5_rst_tick", frame_tick, 0);
    chk("t5_rst_count", hist_count, 0);
    chk("t5_rst_rd_data", hist_rd_data, 0);
    chk("t5_rst_rd_hit", hist_rd_hit, 0);
    reset = 1'b0;
    vsync = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
